// File: rtl/hsk_arb_pkg.sv
// Shared types and the round-robin pick for the half-handshake transmit arbiter.
package hsk_arb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, ACK_LO} state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int MAX_REQ         = 32;
    localparam int MAX_IDX_W       = 5;

    // Returns the first requester at or after last+1, wrapping at n; returns last when none request.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int n);
        int idx;
        rr_pick = last;
        // Walk from the farthest candidate back to the nearest so the nearest one wins.
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (req[idx[MAX_IDX_W-1:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 and returns a one-hot and an index grant.
module rr_arbiter
    import hsk_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         grant_onehot,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int IW = $clog2(N_REQ);

    always_comb begin
        grant_idx    = IW'(rr_pick(MAX_REQ'(req), int'(last), N_REQ));
        grant_onehot = (|req) ? (N_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/half_handshake_tx_arbiter.sv
// Transmit side of the half-handshake CDC channel: round-robin grant, hold word until ack falls.
// Optional ack-wait timeout enabled by defining HSK_TIMEOUT_EN.
module half_handshake_tx_arbiter
    import hsk_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DW             = 32,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk_trasnmit,
    input  logic                     rst_transmit,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [DW-1:0]            data_trndom,
    output logic                     tready,
    input  logic                     rack_trndom,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N_REQ);

    state_t               state, state_n;
    logic [SYNC_STAGES-1:0] rack_sync;
    logic                 rack_s;
    logic [IW-1:0]        last_q, last_n, grant_n, pick_idx;
    logic [N_REQ-1:0]     pick_onehot, req_ready_n;
    logic [DW-1:0]        pick_word, data_n;
    logic                 tready_n;

    // NOTE: the chain resets to 1 so a receiver still acking across our reset blocks any new grant.
    always_ff @(posedge clk_trasnmit or posedge rst_transmit) begin
        if (rst_transmit) rack_sync <= '1;
        else              rack_sync <= {rack_sync[SYNC_STAGES-2:0], rack_trndom};
    end

    assign rack_s = rack_sync[SYNC_STAGES-1];
    assign busy   = (state != IDLE);

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req          (req_valid),
        .last         (last_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) pick_word = req_data[i*DW +: DW];
        end
    end

`ifdef HSK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit, timeout_n;

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_trasnmit or posedge rst_transmit) begin
        if (rst_transmit) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_n;
            if (state_n != state)   tmo_cnt <= '0;
            else if (state != IDLE) tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // NOTE: every variable gets its hold value first, so no branch can infer a latch.
    always_comb begin
        state_n     = state;
        tready_n    = tready;
        data_n      = data_trndom;
        grant_n     = grant_id;
        last_n      = last_q;
        req_ready_n = '0;
`ifdef HSK_TIMEOUT_EN
        timeout_n   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rack_s && (|req_valid)) begin
                    state_n  = REQ;
                    tready_n = 1'b1;
                    data_n   = pick_word;
                    grant_n  = pick_idx;
                    last_n   = pick_idx;
                end
            end
            REQ: begin
                if (rack_s) begin
                    state_n     = ACK_LO;
                    tready_n    = 1'b0;
                    req_ready_n = N_REQ'(1) << grant_id;
                end
`ifdef HSK_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_n     = ACK_LO;
                    tready_n    = 1'b0;
                    req_ready_n = N_REQ'(1) << grant_id;
                    timeout_n   = 1'b1;
                end
`endif
            end
            ACK_LO: begin
                if (!rack_s) state_n = IDLE;
`ifdef HSK_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_trasnmit or posedge rst_transmit) begin
        if (rst_transmit) begin
            state       <= IDLE;
            tready      <= 1'b0;
            req_ready   <= '0;
            data_trndom <= '0;
            grant_id    <= '0;
            last_q      <= IW'(N_REQ - 1);
        end else begin
            state       <= state_n;
            tready      <= tready_n;
            req_ready   <= req_ready_n;
            data_trndom <= data_n;
            grant_id    <= grant_n;
            last_q      <= last_n;
        end
    end

endmodule
